// File: rtl/writeback_stage_if.sv
// writeback_stage_if
// Groups the MEM->WB pipeline inputs and the regfile/CC write-back outputs
// of the LC-3b writeback stage into a single bundle.
//   Upstream side (driven by master, seen by the stage as inputs):
//     stall, valid_in, npc_in, ir_in, alu_in, mem_rdata_in, mem_addr_lsb_in,
//     dr_in, wb_sel_in, ld_reg_in, ld_cc_in
//   Write-back side (driven by the stage, seen by master as inputs):
//     ld_reg_store, ld_cc_store, reg_data, cc_data, dest_reg, valid,
//     npc, ir, retired
interface writeback_stage_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 stall;
  logic                 valid_in;
  logic [15:0]          npc_in;
  logic [15:0]          ir_in;
  logic [15:0]          alu_in;
  logic [15:0]          mem_rdata_in;
  logic                 mem_addr_lsb_in;
  logic [2:0]           dr_in;
  logic [1:0]           wb_sel_in;
  logic                 ld_reg_in;
  logic                 ld_cc_in;

  logic                 ld_reg_store;
  logic                 ld_cc_store;
  logic [15:0]          reg_data;
  logic [2:0]           cc_data;
  logic [2:0]           dest_reg;
  logic                 valid;
  logic [15:0]          npc;
  logic [15:0]          ir;
  logic [CNT_WIDTH-1:0] retired;

  // Upstream / environment view.
  modport master (
    output stall, valid_in, npc_in, ir_in, alu_in, mem_rdata_in,
           mem_addr_lsb_in, dr_in, wb_sel_in, ld_reg_in, ld_cc_in,
    input  ld_reg_store, ld_cc_store, reg_data, cc_data, dest_reg, valid,
           npc, ir, retired
  );

  // Writeback stage view.
  modport slave (
    input  stall, valid_in, npc_in, ir_in, alu_in, mem_rdata_in,
           mem_addr_lsb_in, dr_in, wb_sel_in, ld_reg_in, ld_cc_in,
    output ld_reg_store, ld_cc_store, reg_data, cc_data, dest_reg, valid,
           npc, ir, retired
  );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage
// Final LC-3b pipeline stage. Holds the MEM->WB pipeline register, selects
// the write-back value (ALU, memory word, sign-extended memory byte, NPC),
// derives NZP from it, and fires one-shot regfile/CC write strobes on the
// first cycle each instruction occupies the stage. Also counts retirements.
// Ports:
//   clk     - stage clock, all state on rising edge
//   reset_n - asynchronous active-low reset
//   wb      - writeback_stage_if.slave bundle (pipeline inputs, write-back
//             strobes/data, trace outputs and retired counter)
module writeback_stage #(
  parameter int CNT_WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  writeback_stage_if.slave   wb
);

  logic [15:0]          r_npc;
  logic [15:0]          r_ir;
  logic [15:0]          r_alu;
  logic [15:0]          r_mem_rdata;
  logic                 r_lsb;
  logic [2:0]           r_dr;
  logic [1:0]           r_wb_sel;
  logic                 r_ld_reg;
  logic                 r_ld_cc;
  logic                 r_valid;
  logic                 r_fresh;
  logic [CNT_WIDTH-1:0] r_retired;

  logic                 w_retire;
  logic [7:0]           w_byte;
  logic [15:0]          w_reg_data;
  logic                 w_n;
  logic                 w_z;

  // An instruction retires (and strobes) only in its first resident cycle,
  // so a stall never produces a repeated regfile/CC write.
  assign w_retire = r_valid & r_fresh;

  // Pipeline register and retired counter. While stalled all fields hold and
  // fresh drops, so the held instruction is no longer considered new.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_npc       <= '0;
      r_ir        <= '0;
      r_alu       <= '0;
      r_mem_rdata <= '0;
      r_lsb       <= 1'b0;
      r_dr        <= '0;
      r_wb_sel    <= '0;
      r_ld_reg    <= 1'b0;
      r_ld_cc     <= 1'b0;
      r_valid     <= 1'b0;
      r_fresh     <= 1'b0;
      r_retired   <= '0;
    end else begin
      if (!wb.stall) begin
        r_npc       <= wb.npc_in;
        r_ir        <= wb.ir_in;
        r_alu       <= wb.alu_in;
        r_mem_rdata <= wb.mem_rdata_in;
        r_lsb       <= wb.mem_addr_lsb_in;
        r_dr        <= wb.dr_in;
        r_wb_sel    <= wb.wb_sel_in;
        r_ld_reg    <= wb.ld_reg_in;
        r_ld_cc     <= wb.ld_cc_in;
        r_valid     <= wb.valid_in;
        r_fresh     <= wb.valid_in;
      end else begin
        r_fresh     <= 1'b0;
      end
      if (w_retire) begin
        r_retired <= r_retired + CNT_WIDTH'(1);
      end
    end
  end

  // Byte lane for LDB: odd address selects the high byte.
  assign w_byte = r_lsb ? r_mem_rdata[15:8] : r_mem_rdata[7:0];

  // Write-back value select.
  always_comb begin
    w_reg_data = r_alu;
    case (r_wb_sel)
      2'b00:   w_reg_data = r_alu;
      2'b01:   w_reg_data = r_mem_rdata;
      2'b10:   w_reg_data = {{8{w_byte[7]}}, w_byte};
      2'b11:   w_reg_data = r_npc;
      default: w_reg_data = r_alu;
    endcase
  end

  assign w_n = w_reg_data[15];
  assign w_z = (w_reg_data == 16'h0000);

  assign wb.reg_data     = w_reg_data;
  assign wb.cc_data      = {w_n, w_z, ~w_n & ~w_z};
  assign wb.ld_reg_store = w_retire & r_ld_reg;
  assign wb.ld_cc_store  = w_retire & r_ld_cc;
  assign wb.dest_reg     = r_dr;
  assign wb.valid        = r_valid;
  assign wb.npc          = r_npc;
  assign wb.ir           = r_ir;
  assign wb.retired      = r_retired;

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final LC-3b pipeline stage; the producer side of the register-file/condition-code write interface that the decode stage consumes.
- Holds the MEM→WB pipeline register and selects the write-back value (ALU result, memory word, sign-extended memory byte, or NPC).
- Generates NZP, and drives one-shot regfile/CC write strobes plus a retired-instruction counter.

Parameters:
- CNT_WIDTH, 16, width of retired-instruction counter.

Ports:
- clk  input  1  stage clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- stall  input  1  hold pipeline register (downstream/global stall)
- valid_in  input  1  MEM stage holds a real instruction
- npc_in  input  16  lc3b_word, PC+2 of instruction
- ir_in  input  16  lc3b_word, instruction
- alu_in  input  16  lc3b_word, ALU/address result
- mem_rdata_in  input  16  lc3b_word, data returned by memory
- mem_addr_lsb_in  input  1  bit 0 of data address (byte lane)
- dr_in  input  3  lc3b_reg, destination register
- wb_sel_in  input  2  00 ALU, 01 mem word, 10 mem byte, 11 NPC
- ld_reg_in  input  1  instruction writes regfile
- ld_cc_in  input  1  instruction writes CC
- ld_reg_store  output  1  regfile write strobe
- ld_cc_store  output  1  CC write strobe
- reg_data  output  16  lc3b_word, write-back value
- cc_data  output  3  lc3b_nzp, {n,z,p} of reg_data
- dest_reg  output  3  lc3b_reg, latched destination
- valid  output  1  stage holds a real instruction
- npc  output  16  latched npc (debug/trace)
- ir  output  16  latched ir (debug/trace)
- retired  output  CNT_WIDTH  count of instructions retired

Behaviour:
- Reset (async, reset_n=0): all pipeline registers 0, fresh=0, retired=0. Resulting outputs: valid=0, ld_reg_store=0, ld_cc_store=0, reg_data=0, cc_data=3'b010, dest_reg=0, npc=0, ir=0.
- Pipeline register, stall=0:
  - Latches npc/ir/alu/mem_rdata/lsb/dr/wb_sel/ld_reg/ld_cc.
  - valid<=valid_in.
  - fresh<=valid_in.
- Pipeline register, stall=1: all fields held; fresh<=0. valid_in is ignored (upstream must hold it).
- fresh marks the first cycle an instruction occupies the stage. Strobes fire exactly once per instruction regardless of stall length.
- Strobes (combinational):
  - ld_reg_store = valid & fresh & ld_reg.
  - ld_cc_store = valid & fresh & ld_cc.
  - Bubbles (valid=0) never strobe, even if ld_reg/ld_cc were latched as 1.
- reg_data mux on the latched wb_sel:
  - 00: alu.
  - 01: mem_rdata.
  - 10: byte = lsb ? mem_rdata[15:8] : mem_rdata[7:0], sign-extended to 16 bits (LDB).
  - 11: npc (JSR/JSRR/TRAP link).
- cc_data from reg_data:
  - n = reg_data[15].
  - z = (reg_data == 0).
  - p = !n & !z.
  - Exactly one bit is always set.
- dest_reg = latched dr. Stage does not force R7; dr_in already encodes that.
- Latency: an instruction presented with valid_in=1 and stall=0 at edge k produces its strobes during cycle k→k+1. The decode-side register and CC update at edge k+1.
- retired: +1 on each rising edge where valid & fresh. Wraps modulo 2^CNT_WIDTH; no saturation.
- Back-to-back instructions with no stall: fresh stays 1, one strobe per cycle, retired +1 per cycle.
- Stall arriving in an instruction's first cycle: the strobe still fires that cycle. No repeat while stalled, and no strobe again when the stall releases unless a new instruction is latched.
- Reset mid-operation: the in-flight instruction is discarded with no strobe. Counter clears.

Test Plan:
- Reset: hold reset_n=0 with random inputs → all strobes 0, valid=0, cc_data=010, retired=0.
- ALU write: valid_in=1, wb_sel=00, alu_in=16'h8001, dr_in=3, ld_reg=ld_cc=1 → next cycle ld_reg_store=1, ld_cc_store=1, reg_data=8001, cc_data=100, dest_reg=3, both strobes for exactly one cycle, retired=1.
- LDB byte lanes: mem_rdata=16'h7F80, wb_sel=10. With lsb=0 → reg_data=FF80, cc=100. With lsb=1 → reg_data=007F, cc=001. Word load of 0x0000 → cc=010.
- JSR link: wb_sel=11, npc_in=16'h3002, dr_in=7 → reg_data=3002, dest_reg=7, ld_reg_store=1.
- Stall: latch one instruction, then stall=1 for 4 cycles → single strobe in first cycle, none after stall release, retired increments by 1 only. Bubble (valid_in=0, ld_reg_in=1) → no strobe.
- Counter wrap and async reset: with CNT_WIDTH=4, retire 17 instructions → retired=1. Assert reset_n=0 mid-cycle with valid=1 → outputs clear immediately, without waiting for a clock edge.
